// File: rtl/mall_occupancy_counter_pkg.sv
// Shared types and helpers for the mall occupancy counter: capacity state
// encoding, a small popcount, and the parameter legality rule.
package mall_pkg;

    typedef enum logic [1:0] {
        OPEN      = 2'd0,
        NEAR_FULL = 2'd1,
        FULL      = 2'd2
    } cap_state_t;

    localparam int MIN_GATES   = 1;
    localparam int MAX_GATES   = 8;
    localparam int MIN_COUNT_W = 3;

    // Counts set bits of an up-to-8-gate event vector.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic bit params_legal(input int num_gates, input int count_w,
                                        input int capacity, input int near_thresh,
                                        input int hyst, input int debounce);
        return (num_gates >= MIN_GATES) && (num_gates <= MAX_GATES) &&
               (count_w >= MIN_COUNT_W) && (count_w <= 30) &&
               (capacity < (1 << count_w)) && (near_thresh < capacity) &&
               (hyst < capacity - near_thresh) && (debounce >= 1);
    endfunction

endpackage

// File: rtl/mall_occupancy_counter_gate_debounce.sv
// One door sensor: 2-flop synchroniser, debounce filter and a one-cycle
// pulse on each debounced rising edge.
module gate_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic event_o
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          armed_q, armed_d;
    logic          event_q, event_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          contrary;
    logic          settle;

    // Until a debounced low has been seen after reset the filter behaves as if
    // the level were high, so a sensor held through reset yields no event.
    assign contrary = sync2_q ^ (level_q | ~armed_q);
    assign settle   = contrary && (cnt_q == LAST);

    always_comb begin
        level_d = level_q;
        armed_d = armed_q;
        cnt_d   = '0;
        event_d = settle & sync2_q;
        if (settle) begin
            level_d = sync2_q;
            armed_d = 1'b1;
        end else if (contrary) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            armed_q <= 1'b0;
            event_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            armed_q <= armed_d;
            event_q <= event_d;
            cnt_q   <= cnt_d;
        end
    end

    assign event_o = event_q;

endmodule

// File: rtl/mall_occupancy_counter.sv
// Multi-gate occupancy counter: nets all gate events per cycle, clamps to
// [0, CAPACITY], and runs a hysteretic capacity FSM driving the door lock.
module mall_occupancy_counter
    import mall_pkg::*;
#(
    parameter int NUM_GATES   = 4,
    parameter int COUNT_W     = 8,
    parameter int CAPACITY    = 200,
    parameter int NEAR_THRESH = 180,
    parameter int HYST        = 10,
    parameter int DEBOUNCE    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_GATES-1:0] entry_raw,
    input  logic [NUM_GATES-1:0] exit_raw,
    input  logic                 clear_err,
    output logic [COUNT_W-1:0]   occupancy,
    output logic [COUNT_W-1:0]   total_entries,
    output logic                 near_full,
    output logic                 full,
    output logic                 gate_lock,
    output logic                 overflow_err,
    output logic                 underflow_err
);

    localparam bit CFG_OK = params_legal(NUM_GATES, COUNT_W, CAPACITY, NEAR_THRESH, HYST, DEBOUNCE);
    localparam int SW     = COUNT_W + 2;
    localparam logic signed [SW-1:0] CAP_S   = SW'(CAPACITY);
    localparam logic [COUNT_W-1:0]   CAP_U   = COUNT_W'(CAPACITY);
    localparam logic [COUNT_W-1:0]   NEAR_U  = COUNT_W'(NEAR_THRESH);
    localparam logic [COUNT_W-1:0]   LEAVE_U = COUNT_W'(CAPACITY - HYST);

    if (!CFG_OK) begin : g_bad_cfg
        $error("mall_occupancy_counter: illegal parameter combination");
    end

    logic [NUM_GATES-1:0] entry_evt, exit_evt;
    logic [7:0]           entry_pad, exit_pad;
    logic [3:0]           e_cnt, x_cnt;
    logic signed [SW-1:0] x_s, sum_s, app_s;

    logic [COUNT_W-1:0] occupancy_q, occupancy_d;
    logic [COUNT_W-1:0] total_q, total_d, applied;
    cap_state_t         state_q, state_d;
    logic               ovf_q, ovf_d, unf_q, unf_d;
    logic               ovf_evt, unf_evt;

    for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_gate
        gate_debounce #(.DEBOUNCE(DEBOUNCE)) u_entry (
            .clock(clock), .reset(reset), .raw_i(entry_raw[gi]), .event_o(entry_evt[gi])
        );
        gate_debounce #(.DEBOUNCE(DEBOUNCE)) u_exit (
            .clock(clock), .reset(reset), .raw_i(exit_raw[gi]), .event_o(exit_evt[gi])
        );
    end

    always_comb begin
        entry_pad = '0;
        exit_pad  = '0;
        entry_pad[NUM_GATES-1:0] = entry_evt;
        exit_pad[NUM_GATES-1:0]  = exit_evt;
    end

    assign e_cnt = popcount8(entry_pad);
    assign x_cnt = popcount8(exit_pad);
    assign x_s   = $signed(SW'(x_cnt));
    assign sum_s = $signed({2'b00, occupancy_q}) + $signed(SW'(e_cnt)) - x_s;
    // Entries that fit: whatever brings the count exactly to CAPACITY after exits.
    assign app_s = CAP_S - $signed({2'b00, occupancy_q}) + x_s;

    always_comb begin
        occupancy_d = sum_s[COUNT_W-1:0];
        applied     = COUNT_W'(e_cnt);
        ovf_evt     = 1'b0;
        unf_evt     = 1'b0;
        if (sum_s > CAP_S) begin
            occupancy_d = CAP_U;
            applied     = app_s[COUNT_W-1:0];
            ovf_evt     = 1'b1;
        end else if (sum_s[SW-1]) begin
            occupancy_d = '0;
            unf_evt     = 1'b1;
        end
        total_d = total_q + applied;
        ovf_d   = (ovf_q & ~clear_err) | ovf_evt;
        unf_d   = (unf_q & ~clear_err) | unf_evt;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OPEN: begin
                if (occupancy_d >= CAP_U)       state_d = FULL;
                else if (occupancy_d >= NEAR_U) state_d = NEAR_FULL;
            end
            NEAR_FULL: begin
                if (occupancy_d >= CAP_U)       state_d = FULL;
                else if (occupancy_d < NEAR_U)  state_d = OPEN;
            end
            FULL: begin
                if (occupancy_d < NEAR_U)       state_d = OPEN;
                else if (occupancy_d < LEAVE_U) state_d = NEAR_FULL;
            end
            default: state_d = OPEN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            occupancy_q <= '0;
            total_q     <= '0;
            state_q     <= OPEN;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            occupancy_q <= occupancy_d;
            total_q     <= total_d;
            state_q     <= state_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign occupancy     = occupancy_q;
    assign total_entries = total_q;
    assign near_full     = (state_q != OPEN);
    assign full          = (state_q == FULL);
    assign gate_lock     = (state_q == FULL);
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_mall_occupancy_counter.sv
// Bench for mall_occupancy_counter: reset/latency sequences, a vector table,
// scenario climbs and random traffic against an arithmetic reference model.
module tb_mall_occupancy_counter;

    localparam int CAP  = 200;
    localparam int NEAR = 180;
    localparam int HYST = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] entry_raw = 4'hF;
    logic [3:0] exit_raw  = 4'hF;
    logic       clear_err = 1'b0;
    logic [7:0] occupancy, total_entries;
    logic       near_full, full, gate_lock, overflow_err, underflow_err;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: 0 = open, 1 = near full, 2 = full
    int m_occ, m_tot, m_st, m_ovf, m_unf;

    typedef struct {
        logic [3:0] en;
        logic [3:0] ex;
        int         clr;
        int         occ;
        int         tot;
        int         ovf;
        int         unf;
    } vec_t;
    vec_t tbl[11];

    mall_occupancy_counter dut (
        .clock(clock), .reset(reset), .entry_raw(entry_raw), .exit_raw(exit_raw),
        .clear_err(clear_err), .occupancy(occupancy), .total_entries(total_entries),
        .near_full(near_full), .full(full), .gate_lock(gate_lock),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int nxt_state(input int s, input int o);
        if (o >= CAP && s != 2) return 2;
        if (o < NEAR) return 0;
        if (s == 2 && o < CAP - HYST) return 1;
        if (s == 0) return 1;
        return s;
    endfunction

    // Sensors high for 6 cycles, low for 7; clear_err pulsed at edge clr (-1 none).
    task automatic pulse(input logic [3:0] en, input logic [3:0] ex, input int clr);
        @(posedge clock); #1;
        entry_raw = en; exit_raw = ex; clear_err = (clr == 0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            if (i == 5) begin entry_raw = '0; exit_raw = '0; end
            clear_err = (clr == i + 1);
        end
    endtask

    task automatic check_all(input string tag);
        @(negedge clock);
        chk({tag, "/occ"}, occupancy, m_occ);
        chk({tag, "/total"}, total_entries, m_tot);
        chk({tag, "/near_full"}, near_full, (m_st != 0) ? 1 : 0);
        chk({tag, "/full"}, full, (m_st == 2) ? 1 : 0);
        chk({tag, "/gate_lock"}, gate_lock, (m_st == 2) ? 1 : 0);
        chk({tag, "/ovf"}, overflow_err, m_ovf);
        chk({tag, "/unf"}, underflow_err, m_unf);
    endtask

    task automatic step(input logic [3:0] en, input logic [3:0] ex, input int clr, input string tag);
        int e, x, nxt, app, oe, ue;
        pulse(en, ex, clr);
        e = $countones(en); x = $countones(ex);
        nxt = m_occ + e - x; app = e; oe = 0; ue = 0;
        if (nxt > CAP) begin app = e - (nxt - CAP); nxt = CAP; oe = 1; end
        else if (nxt < 0) begin nxt = 0; ue = 1; end
        m_occ = nxt;
        m_tot = (m_tot + app) % 256;
        m_st  = nxt_state(m_st, m_occ);
        if (clr >= 0 && clr <= 6) begin m_ovf = oe; m_unf = ue; end
        else if (clr > 6) begin m_ovf = 0; m_unf = 0; end
        else begin m_ovf = m_ovf | oe; m_unf = m_unf | ue; end
        $display("step %s en=%h ex=%h clr=%0d -> occ=%0d total=%0d", tag, en, ex, clr, occupancy, total_entries);
        check_all(tag);
    endtask

    task automatic goto_occ(input int target);
        int d;
        logic [3:0] m;
        for (int k = 0; k < 80 && m_occ != target; k++) begin
            d = target - m_occ;
            if (d >= 4) step(4'hF, 4'h0, -1, "goto");
            else if (d > 0) begin m = 4'((1 << d) - 1); step(m, 4'h0, -1, "goto"); end
            else if (d <= -4) step(4'h0, 4'hF, -1, "goto");
            else begin m = 4'((1 << (-d)) - 1); step(4'h0, m, -1, "goto"); end
        end
        chk("goto_reached", occupancy, target);
    endtask

    initial begin
        tbl[0]  = '{4'h0, 4'h1, -1, 0, 1,  0, 0};
        tbl[1]  = '{4'h0, 4'h1, -1, 0, 1,  0, 1};
        tbl[2]  = '{4'h0, 4'h0,  0, 0, 1,  0, 0};
        tbl[3]  = '{4'hF, 4'h0, -1, 4, 5,  0, 0};
        tbl[4]  = '{4'hF, 4'h6, -1, 6, 9,  0, 0};
        tbl[5]  = '{4'h3, 4'hF, -1, 4, 11, 0, 0};
        tbl[6]  = '{4'h0, 4'hF, -1, 0, 11, 0, 0};
        tbl[7]  = '{4'h1, 4'h3, -1, 0, 12, 0, 1};
        tbl[8]  = '{4'h0, 4'h0,  0, 0, 12, 0, 0};
        tbl[9]  = '{4'h0, 4'h1,  6, 0, 12, 0, 1};
        tbl[10] = '{4'h0, 4'h0,  3, 0, 12, 0, 0};

        // reset held with every sensor high
        repeat (2) @(posedge clock);
        m_occ = 0; m_tot = 0; m_st = 0; m_ovf = 0; m_unf = 0;
        check_all("reset");
        @(posedge clock); #1; reset = 1'b1;
        repeat (20) @(posedge clock);
        @(negedge clock);
        chk("held_after_reset/occ", occupancy, 0);
        chk("held_after_reset/exit_unf", underflow_err, 0);
        $display("reset released with sensors held: occ=%0d", occupancy);
        @(posedge clock); #1; entry_raw = '0; exit_raw = '0;
        repeat (12) @(posedge clock);

        // single entry latency: update must land on edge 6
        #1; entry_raw = 4'h1;
        for (int i = 0; i < 6; i++) @(posedge clock);
        #1; entry_raw = '0;
        @(negedge clock);
        chk("latency/before_edge6", occupancy, 0);
        @(posedge clock);
        @(negedge clock);
        chk("latency/after_edge6", occupancy, 1);
        chk("latency/total", total_entries, 1);
        $display("single entry: occ=%0d total=%0d", occupancy, total_entries);

        // 3-cycle glitch is filtered
        @(posedge clock); #1; entry_raw = 4'h1;
        repeat (3) @(posedge clock);
        #1; entry_raw = '0;
        repeat (15) @(posedge clock);
        @(negedge clock);
        chk("glitch/occ", occupancy, 1);
        $display("glitch: occ=%0d", occupancy);

        for (int i = 0; i < 11; i++) begin
            pulse(tbl[i].en, tbl[i].ex, tbl[i].clr);
            @(negedge clock);
            $display("vec %0d en=%h ex=%h clr=%0d -> occ=%0d total=%0d ovf=%0d unf=%0d",
                     i, tbl[i].en, tbl[i].ex, tbl[i].clr, occupancy, total_entries,
                     overflow_err, underflow_err);
            chk($sformatf("vec%0d/occ", i), occupancy, tbl[i].occ);
            chk($sformatf("vec%0d/total", i), total_entries, tbl[i].tot);
            chk($sformatf("vec%0d/ovf", i), overflow_err, tbl[i].ovf);
            chk($sformatf("vec%0d/unf", i), underflow_err, tbl[i].unf);
            chk($sformatf("vec%0d/near_full", i), near_full, 0);
        end
        m_occ = 0; m_tot = 12; m_st = 0; m_ovf = 0; m_unf = 0;

        // simultaneous events from 50
        goto_occ(50);
        step(4'hF, 4'h6, -1, "simul");
        chk("simul/occ52", occupancy, 52);

        // hysteresis climb and saturation
        goto_occ(180);
        chk("climb180/near_full", near_full, 1);
        goto_occ(199);
        step(4'h3, 4'h0, -1, "sat_hi");
        chk("sat_hi/occ200", occupancy, 200);
        chk("sat_hi/ovf", overflow_err, 1);
        chk("sat_hi/gate_lock", gate_lock, 1);
        goto_occ(190);
        chk("hyst190/full", full, 1);
        goto_occ(189);
        chk("hyst189/gate_lock", gate_lock, 0);
        chk("hyst189/near_full", near_full, 1);
        goto_occ(179);
        chk("hyst179/near_full", near_full, 0);

        // random traffic against the model
        for (int i = 0; i < 40; i++) begin
            logic [3:0] en, ex;
            int clr;
            en  = 4'($urandom_range(0, 15));
            ex  = 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : -1;
            step(en, ex, clr, "rand");
        end

        // reset while an entry is mid-debounce at 120
        goto_occ(120);
        @(posedge clock); #1; entry_raw = 4'h1;
        repeat (3) @(posedge clock);
        #1; reset = 1'b0;
        @(posedge clock); #1; reset = 1'b1; entry_raw = '0;
        repeat (20) @(posedge clock);
        m_occ = 0; m_tot = 0; m_st = 0; m_ovf = 0; m_unf = 0;
        check_all("midreset");
        $display("mid-debounce reset: occ=%0d total=%0d", occupancy, total_entries);
        step(4'h1, 4'h0, -1, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
